// File: rtl/msk_aes_drv_pkg.sv
// rtl/msk_aes_drv_pkg.sv - shared types and widths for the masked AES driver
package msk_aes_drv_pkg;

   localparam int BLK_W = 128;
   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      RESEED,
      WAIT_PRNG,
      LOAD,
      START,
      RUN,
      DONE
   } drv_state_e;

endpackage

// File: rtl/msk_share_gen.sv
// rtl/msk_share_gen.sv - splits one 128-bit value into d Boolean shares
module msk_share_gen
   import msk_aes_drv_pkg::*;
#(
   parameter int d = 2
) (
   input  logic [BLK_W-1:0]       i_value,
   input  logic [BLK_W*(d-1)-1:0] i_rnd,
   output logic [BLK_W*d-1:0]     o_shares
);

   logic [BLK_W-1:0] w_mask;

   always_comb begin
      w_mask = '0;
      for (int j = 0; j < d - 1; j++) begin
         w_mask = w_mask ^ i_rnd[BLK_W*j +: BLK_W];
      end
   end

   // Shares of bit i sit side by side at [d*i +: d]; the last share carries the value.
   always_comb begin
      o_shares = '0;
      for (int i = 0; i < BLK_W; i++) begin
         for (int j = 0; j < d - 1; j++) begin
            o_shares[d*i + j] = i_rnd[BLK_W*j + i];
         end
         o_shares[d*i + d - 1] = i_value[i] ^ w_mask[i];
      end
   end

endmodule

// File: rtl/msk_aes_driver.sv
// rtl/msk_aes_driver.sv - host-side sequencer for a d-share masked AES core
// Optional watchdog enabled by defining MSKAES_DRV_TIMEOUT_EN.
module msk_aes_driver
   import msk_aes_drv_pkg::*;
#(
   parameter int d           = 2,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [BLK_W-1:0]           plaintext,
   input  logic [BLK_W-1:0]           key,
   input  logic                       force_reseed,
   input  logic [2*BLK_W*(d-1)-1:0]   rnd,
   output logic                       prng_start_reseed,
   input  logic                       prng_out_valid,
   output logic                       valid_in,
   input  logic                       ready,
   input  logic                       cipher_valid,
   output logic [BLK_W*d-1:0]         sh_plaintext,
   output logic [BLK_W*d-1:0]         sh_key,
   input  logic [BLK_W*d-1:0]         sh_ciphertext,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [BLK_W-1:0]           ciphertext,
   output logic [CNT_W-1:0]           cycles,
   output logic                       timeout
);

   drv_state_e         r_state;
   drv_state_e         w_next;
   logic               r_rst_done;
   logic               r_reseed_pend;
   logic [BLK_W-1:0]   r_pt;
   logic [BLK_W-1:0]   r_key;
   logic [BLK_W-1:0]   r_ct;
   logic [BLK_W*d-1:0] r_sh_pt;
   logic [BLK_W*d-1:0] r_sh_key;
   logic [CNT_W-1:0]   r_cycles;
   logic [BLK_W*d-1:0] w_sh_pt;
   logic [BLK_W*d-1:0] w_sh_key;
   logic [BLK_W-1:0]   w_ct_recomb;
   logic               w_accept;
   logic               w_tmo_fire;

   msk_share_gen #(.d(d)) u_share_pt (
      .i_value  (r_pt),
      .i_rnd    (rnd[BLK_W*(d-1)-1:0]),
      .o_shares (w_sh_pt)
   );

   msk_share_gen #(.d(d)) u_share_key (
      .i_value  (r_key),
      .i_rnd    (rnd[2*BLK_W*(d-1)-1:BLK_W*(d-1)]),
      .o_shares (w_sh_key)
   );

   always_comb begin
      w_ct_recomb = '0;
      for (int i = 0; i < BLK_W; i++) begin
         for (int k = 0; k < d; k++) begin
            w_ct_recomb[i] = w_ct_recomb[i] ^ sh_ciphertext[d*i + k];
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next            = r_state;
      req_ready         = 1'b0;
      prng_start_reseed = 1'b0;
      valid_in          = 1'b0;
      resp_valid        = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = r_rst_done;
            if (req_valid && r_rst_done) w_next = r_reseed_pend ? RESEED : LOAD;
         end
         RESEED: begin
            prng_start_reseed = 1'b1;
            w_next            = WAIT_PRNG;
         end
         WAIT_PRNG: begin
            if (prng_out_valid)  w_next = LOAD;
            else if (w_tmo_fire) w_next = DONE;
         end
         LOAD:  w_next = START;
         START: begin
            valid_in = ready;
            if (ready) w_next = RUN;
         end
         RUN: begin
            if (cipher_valid || w_tmo_fire) w_next = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_accept = req_valid && req_ready;

   // r_rst_done keeps req_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rst_done    <= 1'b0;
         r_reseed_pend <= 1'b1;
         r_pt          <= '0;
         r_key         <= '0;
         r_sh_pt       <= '0;
         r_sh_key      <= '0;
         r_ct          <= '0;
         r_cycles      <= '0;
      end else begin
         r_rst_done <= 1'b1;
         if (force_reseed)           r_reseed_pend <= 1'b1;
         else if (r_state == RESEED) r_reseed_pend <= 1'b0;
         if (w_accept) begin
            r_pt  <= plaintext;
            r_key <= key;
         end
         if (r_state == LOAD) begin
            r_sh_pt  <= w_sh_pt;
            r_sh_key <= w_sh_key;
         end
         if (r_state == START && ready) r_cycles <= CNT_W'(1);
         if (r_state == RUN && cipher_valid) r_ct <= w_ct_recomb;
         else if (w_tmo_fire)                r_ct <= '0;
         if (r_state == RUN && !cipher_valid && !w_tmo_fire && r_cycles != '1)
            r_cycles <= r_cycles + 1'b1;
      end
   end

`ifdef MSKAES_DRV_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] r_wd;
   logic             r_timeout;

   // r_wd is 1 in the first cycle of any state and counts cycles spent there.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wd      <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_wd <= (w_next == r_state) ? r_wd + 1'b1 : CNT_W'(1);
         if (w_accept)        r_timeout <= 1'b0;
         else if (w_tmo_fire) r_timeout <= 1'b1;
      end
   end

   assign w_tmo_fire = (r_wd >= TMO_LIM) &&
                       ((r_state == RUN && !cipher_valid) ||
                        (r_state == WAIT_PRNG && !prng_out_valid));
   assign timeout    = r_timeout;
`else
   assign w_tmo_fire = 1'b0;
   assign timeout    = 1'b0;
`endif

   assign sh_plaintext = r_sh_pt;
   assign sh_key       = r_sh_key;
   assign ciphertext   = r_ct;
   assign cycles       = r_cycles;

endmodule

// File: tb/tb_msk_aes_driver.sv
// tb/tb_msk_aes_driver.sv - directed/random bench for msk_aes_driver (d=2 and d=3 instances)
// Define MSKAES_DRV_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYC=16.
module tb_msk_aes_driver;

`ifdef MSKAES_DRV_TIMEOUT_EN
   localparam int TB_TMO = 16;
`else
   localparam int TB_TMO = 1023;
`endif

   localparam logic [127:0] PT0 = 128'h340737e0a29831318d305a88a8f64332;
   localparam logic [127:0] K0  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
   localparam logic [127:0] CT0 = 128'h320b6a19978511dcfb09dc021d842539;

   logic         clk, nrst;
   logic         req_valid, req_ready, force_reseed, prng_start_reseed, prng_out_valid;
   logic         valid_in, core_ready, cipher_valid, resp_valid, resp_ready, timeout;
   logic [127:0] plaintext, key, ciphertext;
   logic [255:0] rnd, sh_plaintext, sh_key, sh_ciphertext;
   logic [15:0]  cycles;

   logic         req_valid3, req_ready3, prng_start_reseed3, valid_in3, resp_valid3, timeout3;
   logic [127:0] plaintext3, key3, ciphertext3;
   logic [511:0] rnd3;
   logic [383:0] sh_plaintext3, sh_key3;
   logic [15:0]  cycles3;

   int           checks, errors;
   int           core_cnt, core_lat;
   bit           core_emit, stray_req;
   logic [127:0] core_res;

   msk_aes_driver #(.d(2), .TIMEOUT_CYC(TB_TMO)) u_dut (
      .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready),
      .plaintext(plaintext), .key(key), .force_reseed(force_reseed), .rnd(rnd),
      .prng_start_reseed(prng_start_reseed), .prng_out_valid(prng_out_valid),
      .valid_in(valid_in), .ready(core_ready), .cipher_valid(cipher_valid),
      .sh_plaintext(sh_plaintext), .sh_key(sh_key), .sh_ciphertext(sh_ciphertext),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .ciphertext(ciphertext),
      .cycles(cycles), .timeout(timeout)
   );

   msk_aes_driver #(.d(3), .TIMEOUT_CYC(TB_TMO)) u_dut3 (
      .clk(clk), .nrst(nrst), .req_valid(req_valid3), .req_ready(req_ready3),
      .plaintext(plaintext3), .key(key3), .force_reseed(1'b0), .rnd(rnd3),
      .prng_start_reseed(prng_start_reseed3), .prng_out_valid(1'b1),
      .valid_in(valid_in3), .ready(1'b1), .cipher_valid(1'b1),
      .sh_plaintext(sh_plaintext3), .sh_key(sh_key3), .sh_ciphertext(384'd0),
      .resp_valid(resp_valid3), .resp_ready(1'b1), .ciphertext(ciphertext3),
      .cycles(cycles3), .timeout(timeout3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [127:0] recomb(input logic [383:0] sh, input int dd);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 128; i++)
         for (int k = 0; k < dd; k++) r[i] = r[i] ^ sh[dd*i + k];
      return r;
   endfunction

   function automatic logic [127:0] share_k(input logic [383:0] sh, input int dd, input int k);
      logic [127:0] r;
      for (int i = 0; i < 128; i++) r[i] = sh[dd*i + k];
      return r;
   endfunction

   function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] k);
      if (pt == PT0 && k == K0) return CT0;
      return pt ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Behavioural masked core: unmasks operands, computes core_fn, re-shares the result.
   initial begin
      core_ready = 1'b1; cipher_valid = 1'b0; sh_ciphertext = '0; core_cnt = 0; core_res = '0;
      forever begin
         @(negedge clk);
         cipher_valid  = stray_req;
         sh_ciphertext = {rnd128(), rnd128()};
         if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
               logic [127:0] m;
               m = rnd128();
               core_ready   = 1'b1;
               cipher_valid = core_emit;
               for (int i = 0; i < 128; i++) begin
                  sh_ciphertext[2*i]   = m[i];
                  sh_ciphertext[2*i+1] = core_res[i] ^ m[i];
               end
            end else begin
               core_ready = 1'b0;
            end
         end else if (valid_in) begin
            core_res = core_fn(recomb(sh_plaintext, 2), recomb(sh_key, 2));
            core_cnt = core_lat;
         end
      end
   end

   task automatic wait_core_idle();
      int n;
      n = 0;
      while (core_cnt != 0 && n < 100) begin @(negedge clk); n++; end
   endtask

   task automatic run_op(input string tag, input logic [127:0] pt, input logic [127:0] k,
                         input int lat, input int hold, input int exp_reseeds,
                         input int prng_dly, input bit emit, input bit exp_tmo);
      logic [127:0] exp_ct;
      logic [255:0] r;
      int n, vin_at, reseeds, exp_cyc, exp_vin;
      exp_ct  = exp_tmo ? 128'd0 : core_fn(pt, k);
      exp_cyc = exp_tmo ? TB_TMO : lat;
      exp_vin = (exp_reseeds != 0) ? 2 + ((prng_dly > 2) ? prng_dly : 2) : 2;
      wait_core_idle();
      core_lat  = lat;
      core_emit = emit;
      n = 0;
      while (!req_ready && n < 400) begin @(negedge clk); n++; end
      chk({tag, "_req_ready"}, req_ready, 1);
      r = {rnd128(), rnd128()};
      req_valid = 1'b1; plaintext = pt; key = k; rnd = r;
      prng_out_valid = (prng_dly == 0);
      vin_at = -1; reseeds = 0; n = 0;
      do begin
         @(negedge clk);
         n++;
         req_valid = 1'b0; plaintext = ~pt; key = ~k;
         prng_out_valid = (n >= prng_dly);
         if (prng_start_reseed) reseeds++;
         if (valid_in && vin_at < 0) begin
            vin_at = n;
            chk({tag, "_sh_pt_xor"}, recomb(sh_plaintext, 2), pt);
            chk({tag, "_sh_key_xor"}, recomb(sh_key, 2), k);
            chk({tag, "_sh_pt_s0"}, share_k(sh_plaintext, 2, 0), r[127:0]);
            chk({tag, "_sh_key_s0"}, share_k(sh_key, 2, 0), r[255:128]);
            rnd = {rnd128(), rnd128()};
         end
      end while (!resp_valid && n < 400);
      chk({tag, "_reseeds"}, reseeds, exp_reseeds);
      chk({tag, "_vin_lat"}, vin_at, exp_vin);
      chk({tag, "_resp_valid"}, resp_valid, 1);
      chk({tag, "_resp_lat"}, n, vin_at + exp_cyc + 1);
      chk({tag, "_ct"}, ciphertext, exp_ct);
      chk({tag, "_cycles"}, cycles, exp_cyc);
      chk({tag, "_timeout"}, timeout, exp_tmo);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk({tag, "_hold_rv"}, resp_valid, 1);
         chk({tag, "_hold_ct"}, ciphertext, exp_ct);
         chk({tag, "_hold_rdy"}, req_ready, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, "_rv_drop"}, resp_valid, 0);
      chk({tag, "_idle_rdy"}, req_ready, 1);
   endtask

   initial begin
      int n, seen;
      logic [127:0] p, q, last_ct;
      logic [383:0] exp3;
      checks = 0; errors = 0;
      core_lat = 1; core_emit = 1'b1; stray_req = 1'b0;
      nrst = 1'b0; req_valid = 1'b0; plaintext = '0; key = '0; rnd = '0;
      force_reseed = 1'b0; prng_out_valid = 1'b1; resp_ready = 1'b0;
      req_valid3 = 1'b0; plaintext3 = '0; key3 = '0; rnd3 = '0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_sh_pt", sh_plaintext, 0);
      chk("rst_ct_cycles", {ciphertext, cycles}, 0);
      nrst = 1'b1;
      #1 chk("rel_req_ready_low", req_ready, 0);
      @(negedge clk);
      chk("rel_req_ready_high", req_ready, 1);

      run_op("vec", PT0, K0, 4, 0, 1, 0, 1'b1, 1'b0);
      last_ct = core_fn(rnd128(), rnd128());
      p = rnd128(); q = rnd128();
      run_op("norsd", p, q, 2, 5, 0, 0, 1'b1, 1'b0);
      last_ct = core_fn(p, q);

      stray_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("stray_rv", resp_valid, 0);
         chk("stray_rdy", req_ready, 1);
      end
      stray_req = 1'b0;
      @(negedge clk);
      chk("stray_ct", ciphertext, last_ct);

      force_reseed = 1'b1;
      @(negedge clk);
      force_reseed = 1'b0;
      run_op("frc", rnd128(), rnd128(), 3, 1, 1, 5, 1'b1, 1'b0);

      for (int t = 0; t < 4; t++)
         run_op("rand", rnd128(), rnd128(), $urandom_range(1, 6), $urandom_range(0, 2), 0, 0, 1'b1, 1'b0);

      for (int t = 0; t < 4; t++) begin
         p = rnd128(); q = rnd128();
         if (t == 0) rnd3 = '0;
         else for (int w = 0; w < 16; w++) rnd3[32*w +: 32] = $urandom();
         n = 0;
         while (!req_ready3 && n < 50) begin @(negedge clk); n++; end
         req_valid3 = 1'b1; plaintext3 = p; key3 = q;
         n = 0;
         do begin @(negedge clk); n++; req_valid3 = 1'b0; end while (!valid_in3 && n < 50);
         chk("d3_vin", valid_in3, 1);
         chk("d3_pt_xor", recomb(sh_plaintext3, 3), p);
         chk("d3_key_xor", recomb(sh_key3, 3), q);
         if (t == 0) begin
            exp3 = '0;
            for (int i = 0; i < 128; i++) exp3[3*i+2] = p[i];
            chk("d3_zero_rnd_sh", sh_plaintext3, exp3);
         end else begin
            chk("d3_pt_s1", share_k(sh_plaintext3, 3, 1), rnd3[255:128]);
         end
      end

      wait_core_idle();
      core_emit = 1'b0; core_lat = 20;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      req_valid = 1'b1; plaintext = rnd128(); key = rnd128();
      n = 0;
      do begin @(negedge clk); n++; req_valid = 1'b0; end while (!valid_in && n < 20);
      repeat (3) @(negedge clk);
      nrst = 1'b0;
      #1;
      chk("mid_rst_flags", {req_ready, resp_valid, valid_in, prng_start_reseed, timeout}, 0);
      chk("mid_rst_ct", ciphertext, 0);
      chk("mid_rst_cycles", cycles, 0);
      chk("mid_rst_sh", {sh_plaintext, sh_key}, 0);
      @(negedge clk);
      nrst = 1'b1;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      chk("mid_rst_no_resp", seen, 0);
      run_op("after_rst", rnd128(), rnd128(), 5, 0, 1, 0, 1'b1, 1'b0);

`ifdef MSKAES_DRV_TIMEOUT_EN
      run_op("tmo", rnd128(), rnd128(), 30, 2, 0, 0, 1'b0, 1'b1);
      run_op("tmo_clr", rnd128(), rnd128(), 2, 0, 0, 0, 1'b1, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
